branch_target_predictor: RTL and testbench

- Direct-mapped branch target buffer with 2-bit saturating direction counters, one entry per index.
- Upstream of fu_branch: fetch queries it by PC; the predicted direction travels with the instruction and reaches the branch FU as predicted_outcome.
- Downstream of fu_branch: it consumes the FU's update_btb / update_pc / branch_target / branch_outcome / miss results to train the table.
- Includes a sequential table-flush walker and a misprediction counter.

---
 rtl/branch_target_predictor.sv | 230 +++++++++++++++++++++++
 tb/tb_branch_target_predictor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, a sequential
// invalidate-all walker and a misprediction counter.
module branch_target_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_btb,
  input  logic [31:0] update_pc,
  input  logic [31:0] branch_target,
  input  logic        branch_outcome,
  input  logic        miss,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    logic [1:0] r;
    if (up) begin
      r = (c == 2'b11) ? c : c + 2'd1;
    end else begin
      r = (c == 2'b00) ? c : c - 2'd1;
    end
    return r;
  endfunction

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic             busy_q;
  logic [31:0]      mispredict_q;

  logic             pred_valid_q;
  logic             pred_hit_q;
  logic             pred_taken_q;
  logic [31:0]      pred_target_q;

  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_en_s;
  logic             upd_hit_s;
  logic             wr_en_d;
  logic             ent_valid_d;
  logic [TAG_W-1:0] ent_tag_d;
  logic [31:0]      ent_tgt_d;
  logic [1:0]       ent_ctr_d;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_valid_s;
  logic [TAG_W-1:0] lk_etag_s;
  logic [31:0]      lk_etgt_s;
  logic [1:0]       lk_ectr_s;
  logic             lk_hit_s;
  logic             lk_taken_s;
  logic [31:0]      lk_target_s;

  logic             unused_pc_bits_s;
  assign unused_pc_bits_s = ^{fetch_pc[1:0], update_pc[1:0]};

  // Training: compute the entry image that an accepted update would write.
  always_comb begin
    upd_idx_s   = update_pc[IDX_W+1:2];
    upd_tag_s   = update_pc[31:IDX_W+2];
    upd_en_s    = update_btb && (state_q == ST_IDLE) && !flush;
    upd_hit_s   = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
    wr_en_d     = 1'b0;
    ent_valid_d = valid_q[upd_idx_s];
    ent_tag_d   = tag_q[upd_idx_s];
    ent_tgt_d   = tgt_q[upd_idx_s];
    ent_ctr_d   = ctr_q[upd_idx_s];
    if (upd_en_s) begin
      if (upd_hit_s) begin
        wr_en_d   = 1'b1;
        ent_ctr_d = sat_ctr(ctr_q[upd_idx_s], branch_outcome);
        if (branch_outcome) begin
          ent_tgt_d = branch_target;
        end else begin
          ent_tgt_d = tgt_q[upd_idx_s];
        end
      end else if (branch_outcome) begin
        wr_en_d     = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = upd_tag_s;
        ent_tgt_d   = branch_target;
        ent_ctr_d   = 2'b10;
      end else begin
        wr_en_d = 1'b0;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // Lookup with write-first forwarding of a same-index update.
  always_comb begin
    lk_idx_s = fetch_pc[IDX_W+1:2];
    lk_tag_s = fetch_pc[31:IDX_W+2];
    if (wr_en_d && (lk_idx_s == upd_idx_s)) begin
      lk_valid_s = ent_valid_d;
      lk_etag_s  = ent_tag_d;
      lk_etgt_s  = ent_tgt_d;
      lk_ectr_s  = ent_ctr_d;
    end else begin
      lk_valid_s = valid_q[lk_idx_s];
      lk_etag_s  = tag_q[lk_idx_s];
      lk_etgt_s  = tgt_q[lk_idx_s];
      lk_ectr_s  = ctr_q[lk_idx_s];
    end
    lk_hit_s   = (state_q == ST_IDLE) && lk_valid_s && (lk_etag_s == lk_tag_s);
    lk_taken_s = lk_hit_s && lk_ectr_s[1];
    if (lk_taken_s) begin
      lk_target_s = lk_etgt_s;
    end else begin
      lk_target_s = fetch_pc + 32'd4;
    end
  end

  // Table storage: reset, walker invalidation, or training write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 32'd0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (state_q == ST_CLEAR) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (wr_en_d) begin
      valid_q[upd_idx_s] <= ent_valid_d;
      tag_q[upd_idx_s]   <= ent_tag_d;
      tgt_q[upd_idx_s]   <= ent_tgt_d;
      ctr_q[upd_idx_s]   <= ent_ctr_d;
    end else begin
      valid_q[upd_idx_s] <= valid_q[upd_idx_s];
    end
  end

  // Flush walker; a flush seen while clearing is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (ptr_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q  <= ptr_q + 1'b1;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ptr_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Prediction outputs and misprediction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
      mispredict_q  <= 32'd0;
    end else begin
      pred_valid_q <= fetch_valid;
      if (fetch_valid) begin
        pred_hit_q    <= lk_hit_s;
        pred_taken_q  <= lk_taken_s;
        pred_target_q <= lk_target_s;
      end else begin
        pred_hit_q    <= pred_hit_q;
        pred_taken_q  <= pred_taken_q;
        pred_target_q <= pred_target_q;
      end
      if (update_btb && miss) begin
        mispredict_q <= mispredict_q + 32'd1;
      end else begin
        mispredict_q <= mispredict_q;
      end
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_hit         = pred_hit_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign busy             = busy_q;
  assign mispredict_count = mispredict_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with hand-computed expectations.
module tb_branch_target_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_btb;
  logic [31:0] update_pc;
  logic [31:0] branch_target;
  logic        branch_outcome;
  logic        miss;
  logic        flush;
  logic        busy;
  logic [31:0] mispredict_count;

  int n_cmp = 0;
  int n_bad = 0;

  branch_target_predictor #(.ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .update_btb(update_btb), .update_pc(update_pc), .branch_target(branch_target),
    .branch_outcome(branch_outcome), .miss(miss), .flush(flush),
    .busy(busy), .mispredict_count(mispredict_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic ms);
    update_btb     = 1'b1;
    update_pc      = pc;
    branch_target  = tgt;
    branch_outcome = tk;
    miss           = ms;
    tick();
    update_btb = 1'b0;
    miss       = 1'b0;
  endtask

  task automatic expect_pred(input string tag, input logic h, input logic t, input logic [31:0] tgt);
    check_eq({tag, ".valid"}, {31'd0, pred_valid}, 32'd1);
    check_eq({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, h});
    check_eq({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
    check_eq({tag, ".target"}, pred_target, tgt);
  endtask

  initial begin
    int n;
    RST = 1'b1; fetch_valid = 1'b0; fetch_pc = 32'd0;
    update_btb = 1'b0; update_pc = 32'd0; branch_target = 32'd0;
    branch_outcome = 1'b0; miss = 1'b0; flush = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check_eq("rst.pred_valid", {31'd0, pred_valid}, 32'd0);
    check_eq("rst.pred_hit", {31'd0, pred_hit}, 32'd0);
    check_eq("rst.pred_target", pred_target, 32'd0);
    check_eq("rst.busy", {31'd0, busy}, 32'd0);
    check_eq("rst.count", mispredict_count, 32'd0);

    lookup(32'h100);
    expect_pred("cold", 1'b0, 1'b0, 32'h104);
    tick();
    check_eq("idle.pred_valid", {31'd0, pred_valid}, 32'd0);
    check_eq("idle.hold_target", pred_target, 32'h104);

    // allocate weak-taken, then train down to strongly not-taken
    upd(32'h100, 32'h200, 1'b1, 1'b0);
    lookup(32'h100);
    expect_pred("alloc", 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'hDEAD0000, 1'b0, 1'b0);
    upd(32'h100, 32'hDEAD0000, 1'b0, 1'b0);
    lookup(32'h100);
    expect_pred("ctr00", 1'b1, 1'b0, 32'h104);
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, 1'b1, 1'b0);
    upd(32'h100, 32'hDEAD0000, 1'b0, 1'b0);
    lookup(32'h100);
    expect_pred("sat11_dec", 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'hDEAD0000, 1'b0, 1'b0);
    lookup(32'h100);
    expect_pred("ctr01", 1'b1, 1'b0, 32'h104);

    // alias at index 0 with a different tag
    upd(32'h140, 32'h500, 1'b1, 1'b0);
    lookup(32'h100);
    expect_pred("alias_old", 1'b0, 1'b0, 32'h104);
    upd(32'h100, 32'h777, 1'b0, 1'b0);
    lookup(32'h140);
    expect_pred("alias_new", 1'b1, 1'b1, 32'h500);

    // same-edge update and lookup
    update_btb = 1'b1; update_pc = 32'h180; branch_target = 32'h300; branch_outcome = 1'b1;
    fetch_valid = 1'b1; fetch_pc = 32'h180;
    tick();
    update_btb = 1'b0; fetch_valid = 1'b0;
    expect_pred("fwd", 1'b1, 1'b1, 32'h300);

    lookup(32'hFFFFFFFC);
    expect_pred("wrap", 1'b0, 1'b0, 32'h0);

    // flush walk
    upd(32'h200, 32'h1000, 1'b1, 1'b1);
    upd(32'h204, 32'h1004, 1'b1, 1'b1);
    upd(32'h208, 32'h1008, 1'b1, 1'b1);
    upd(32'h20C, 32'h100C, 1'b1, 1'b1);
    check_eq("cnt4", mispredict_count, 32'd4);
    lookup(32'h20C);
    expect_pred("pre_flush", 1'b1, 1'b1, 32'h100C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      fetch_valid = (n == 2);
      fetch_pc    = 32'h20C;
      update_btb  = (n == 5);
      update_pc   = 32'h240; branch_target = 32'h999; branch_outcome = 1'b1;
      miss        = (n == 5);
      flush       = (n == 10);
      tick();
      if (n == 2) expect_pred("mid_walk", 1'b0, 1'b0, 32'h210);
    end
    fetch_valid = 1'b0; update_btb = 1'b0; miss = 1'b0; flush = 1'b0;
    check_eq("busy_cycles", n, 32'd16);
    check_eq("cnt5", mispredict_count, 32'd5);
    lookup(32'h200); expect_pred("post0", 1'b0, 1'b0, 32'h204);
    lookup(32'h204); expect_pred("post1", 1'b0, 1'b0, 32'h208);
    lookup(32'h20C); expect_pred("post3", 1'b0, 1'b0, 32'h210);
    lookup(32'h240); expect_pred("dropped", 1'b0, 1'b0, 32'h244);

    // reset in the middle of a walk
    for (int i = 0; i < 5; i++) upd(32'h33C, 32'h4000, 1'b1, 1'b1);
    check_eq("cnt10", mispredict_count, 32'd10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick(); tick();
    check_eq("walk_busy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("rst2.busy", {31'd0, busy}, 32'd0);
    check_eq("rst2.count", mispredict_count, 32'd0);
    check_eq("rst2.pred_valid", {31'd0, pred_valid}, 32'd0);
    lookup(32'h33C);
    expect_pred("rst2.lookup", 1'b0, 1'b0, 32'h340);
    check_eq("rst2.busy_after", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
